// File: rtl/opcode_xfer_engine_pkg.sv
// opcode_xfer_pkg: shared types for the opcode/transfer engine.
//   state_e  - engine FSM states
//   OP_*     - command opcodes; OP_ALU_OUT carries wildcards and is only
//              meaningful as a casez item
package opcode_xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WR,
    S_RD_ADDR,
    S_RD_DATA
  } state_e;

  localparam logic [2:0] OP_ALU_OUT = 3'b1??;
  localparam logic [2:0] OP_SWAP    = 3'b001;
  localparam logic [2:0] OP_INC     = 3'b010;
  localparam logic [2:0] OP_BLK_WR  = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b011;

endpackage

// File: rtl/opcode_xfer_engine_if.sv
// opcode_xfer_if: command, write-stream and read-stream bundle.
//   slave  - engine side (accepts commands, sinks wr stream, sources rd stream)
//   master - sequencer / bus side
interface opcode_xfer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              blk_xfer;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] accum;
  logic              done;

  modport slave (
    input  cmd_valid, opcode, cmd_addr, cmd_len, blk_xfer, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, alu_out, accum, done
  );

  modport master (
    output cmd_valid, opcode, cmd_addr, cmd_len, blk_xfer, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, alu_out, accum, done
  );
endinterface

// File: rtl/opcode_xfer_engine_ram.sv
// xfer_ram: single-port synchronous RAM, DATA_W x 2**ADDR_W, no reset.
//   we/wdata - write at addr on the rising edge
//   re       - capture mem[addr] into rdata (1-cycle latency); rdata holds
//              while re is low so a stalled read-out stays stable
module xfer_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/opcode_xfer_engine.sv
// opcode_xfer_engine: accumulator + DEPTH-word RAM executing one command at
// a time from a valid/ready command port.
//   clk, rst_n - clock, async active-low reset
//   bus        - opcode_xfer_if.slave: command port, write stream (bursts
//                into RAM), read stream (sequential read-out), alu_out,
//                accum, done pulse
module opcode_xfer_engine
  import opcode_xfer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int BURST  = 5
) (
  input logic         clk,
  input logic         rst_n,
  opcode_xfer_if.slave bus
);
  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [7:0]        beat_q, beat_d;
  logic [DATA_W-1:0] accum_q, accum_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              done_q, done_d;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      accum_q <= '0;
      alu_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      accum_q <= accum_d;
      alu_q   <= alu_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    accum_d = accum_q;
    alu_d   = alu_q;
    done_d  = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        op_d   = bus.opcode;
        addr_d = bus.cmd_addr;
        rem_d  = bus.cmd_len;
        beat_d = '0;
        casez (bus.opcode)
          OP_ALU_OUT: state_d = S_EXEC;
          OP_SWAP:    state_d = S_EXEC;
          OP_BLK_WR:  state_d = S_WR;
          OP_LOAD:    state_d = S_RD_ADDR;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        // Only ALU opcodes reach here; default covers OP_INC.
        casez (op_q)
          OP_ALU_OUT: alu_d   = accum_q;
          OP_SWAP:    accum_d = {accum_q[DATA_W/2-1:0], accum_q[DATA_W-1:DATA_W/2]};
          default:    accum_d = accum_q + DATA_W'(1);
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WR: if (bus.wr_valid) begin
        ram_we = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (beat_q == 8'(BURST - 1)) begin
          // Burst boundary: blk_xfer decides whether another burst follows.
          beat_d = '0;
          if (!bus.blk_xfer) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_RD_ADDR: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ram_re  = 1'b1;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: if (bus.rd_ready) begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - (ADDR_W+1)'(1);
        if (rem_q == (ADDR_W+1)'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  xfer_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (bus.wr_data),
    .rdata (ram_rdata)
  );

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_WR);
  assign bus.rd_valid  = (state_q == S_RD_DATA);
  // RAM output is unreset; gate it so rd_data reads zero outside a beat.
  assign bus.rd_data   = bus.rd_valid ? ram_rdata : '0;
  assign bus.alu_out   = alu_q;
  assign bus.accum     = accum_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_opcode_xfer_engine.sv
// Randomized self-checking bench for opcode_xfer_engine against a
// behavioural model (accumulator value plus an array image of the RAM).
module tb_opcode_xfer_engine;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BURST = 5;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opcode_xfer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  opcode_xfer_engine #(.DATA_W(DW), .ADDR_W(AW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] ram_m [DEPTH];
  bit            ram_vld [DEPTH];
  logic [DW-1:0] acc_m, alu_m;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW:0] len);
    chk("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.opcode = op;
    bus.cmd_addr = a;
    bus.cmd_len = len;
    tick();
    bus.cmd_valid = 1'b0;
    bus.opcode = 3'($urandom);
    chk("cmd_ready_drop", bus.cmd_ready, 0);
    chk("done_single", bus.done, 0);
  endtask

  task automatic do_alu(input logic [2:0] op);
    accept(op, AW'($urandom), (AW+1)'($urandom));
    if (op[2]) alu_m = acc_m;
    else if (op == 3'b001) acc_m = DW'((acc_m << (DW/2)) | (acc_m >> (DW/2)));
    else acc_m = DW'(acc_m + 1);
    tick();
    chk("alu_done", bus.done, 1);
    chk("accum", bus.accum, acc_m);
    chk("alu_out", bus.alu_out, alu_m);
  endtask

  // vmode: 0 random wr_valid, 1 toggle every other cycle, 2 always valid.
  // dbase < 0 gives random data, else data = dbase + beat index.
  task automatic do_wr(input logic [AW-1:0] a, input int nb, input int vmode, input int dbase);
    int beats = 0;
    int total = nb * BURST;
    int cyc = 0;
    logic [AW-1:0] p = a;
    bit v;
    accept(3'b000, a, '0);
    while (beats < total && cyc < 2000) begin
      chk("wr_ready", bus.wr_ready, 1);
      v = (vmode == 2) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      bus.wr_valid = v;
      bus.wr_data = (dbase < 0) ? DW'($urandom) : DW'(dbase + beats);
      // blk_xfer only matters on the last beat of a burst; noise elsewhere.
      bus.blk_xfer = ((beats % BURST) == BURST - 1) ? (beats / BURST < nb - 1) : 1'($urandom);
      if (v) begin
        ram_m[p] = bus.wr_data;
        ram_vld[p] = 1'b1;
        p++;
        beats++;
      end
      tick();
      cyc++;
      if (beats < total) chk("wr_done_early", bus.done, 0);
    end
    bus.wr_valid = 1'b0;
    chk("wr_beats", beats, total);
    chk("wr_done", bus.done, 1);
    chk("wr_ready_off", bus.wr_ready, 0);
  endtask

  // smode: 0 random rd_ready, 1 hold rd_ready low 3 cycles on beat index 1.
  task automatic do_rd(input logic [AW-1:0] a, input int len, input int smode);
    logic [AW-1:0] p = a;
    int rem = len;
    int cyc = 0;
    int beat = 0;
    int stall = 0;
    bit hs;
    bit r;
    accept(3'b011, a, (AW+1)'(len));
    if (len == 0) begin
      chk("rd_valid_len0", bus.rd_valid, 0);
      tick();
    end
    while (rem > 0 && cyc < 4000) begin
      chk("rd_valid_gap", bus.rd_valid, 0);
      bus.rd_ready = 1'($urandom);
      tick();
      cyc++;
      hs = 1'b0;
      while (!hs && cyc < 4000) begin
        chk("rd_valid", bus.rd_valid, 1);
        if (!bus.rd_valid) cyc = 4000;
        if (ram_vld[p]) chk("rd_data", bus.rd_data, ram_m[p]);
        if (smode == 1 && beat == 1 && stall < 3) begin
          r = 1'b0;
          stall++;
        end else begin
          r = (smode == 1) ? 1'b1 : 1'($urandom);
        end
        bus.rd_ready = r;
        hs = r;
        tick();
        cyc++;
      end
      p++;
      rem--;
      beat++;
      if (rem > 0) chk("rd_done_early", bus.done, 0);
    end
    bus.rd_ready = 1'b0;
    chk("rd_done", bus.done, 1);
    chk("rd_valid_off", bus.rd_valid, 0);
  endtask

  task automatic chk_reset_outs;
    chk("rst_accum", bus.accum, 0);
    chk("rst_alu_out", bus.alu_out, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
  endtask

  initial begin
    logic [2:0] op;
    bus.cmd_valid = 1'b0;
    bus.opcode = '0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.blk_xfer = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram_vld[i] = 1'b0;
    acc_m = '0;
    alu_m = '0;

    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_outs();
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Directed sequence
    do_alu(3'b010);
    do_alu(3'b010);
    do_alu(3'b010);
    chk("inc3_const", bus.accum, 16'h0003);
    do_alu(3'b001);
    chk("swap_const", bus.accum, 16'h0300);
    do_alu(3'b110);
    chk("alu_out_const", bus.alu_out, 16'h0300);
    chk("accum_kept", bus.accum, 16'h0300);
    do_wr(8'hFE, 1, 1, 'hA0);
    do_wr(8'h10, 2, 0, -1);
    do_rd(8'hFE, 5, 1);
    do_rd(8'h10, 10, 0);
    do_rd(8'h40, 0, 0);

    // Reset in the middle of a burst after two beats
    accept(3'b000, 8'hFE, '0);
    for (int b = 0; b < 2; b++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = DW'(16'hB0 + b);
      bus.blk_xfer = 1'b0;
      ram_m[8'(8'hFE + b)] = bus.wr_data;
      tick();
    end
    bus.wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    acc_m = '0;
    alu_m = '0;
    chk_reset_outs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", bus.cmd_ready, 1);
    chk("rel_done", bus.done, 0);
    do_rd(8'hFE, 2, 0);
    chk("rst_accum_after", bus.accum, 0);

    // Randomized command mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 4)
        0: begin
          op = 3'($urandom);
          if (op == 3'b000 || op == 3'b011) op = 3'b010;
          do_alu(op);
        end
        1: do_wr(AW'($urandom), 1 + int'($urandom % 3), 0, -1);
        default: do_rd(AW'($urandom), int'($urandom % 14), 0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/opcode_xfer_engine.md
Name: opcode_xfer_engine

Overview:
- Parametrised, handshaked successor to the team's casez-opcode accumulator/RAM block-transfer logic.
- Holds an accumulator and an internal DEPTH-word RAM, and executes one command at a time from a valid/ready command port.
- Commands: single-cycle ALU ops, burst writes from a data stream into RAM (repeating while a continue flag is held), and sequential RAM read-out to a stream.
- Sits between a command sequencer and a data bus.

Parameters:
DATA_W, 16, data/accumulator width; must be even (byte/half swap).
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W.
BURST, 5, words per write burst; 1..255.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  high only in IDLE.
opcode  in  3  command opcode, sampled on cmd_valid&&cmd_ready.
cmd_addr  in  ADDR_W  start RAM address.
cmd_len  in  ADDR_W+1  word count for read-out.
blk_xfer  in  1  continue flag; sampled at each burst end.
wr_valid  in  1  write-stream data valid.
wr_ready  out  1  high in WR state.
wr_data  in  DATA_W  write-stream data.
rd_valid  out  1  read-stream data valid.
rd_ready  in  1  read-stream consumer ready.
rd_data  out  DATA_W  read-stream data.
alu_out  out  DATA_W  registered ALU result.
accum  out  DATA_W  accumulator value.
done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE; accum, alu_out, rd_data=0; rd_valid, done, wr_ready=0; cmd_ready=1 after release. RAM contents are not reset.
- Reset mid-command aborts it immediately. Partially written RAM words remain. No done pulse is issued.
- Command accepted on cmd_valid&&cmd_ready. opcode, cmd_addr and cmd_len are latched. cmd_ready drops the next cycle.
- Opcode decode (casez priority):
  - 3'b1??: alu_out<=accum.
  - 3'b001: accum<={accum[DATA_W/2-1:0],accum[DATA_W-1:DATA_W/2]} (half swap).
  - 3'b000: burst write.
  - 3'b011: read-out.
  - Default (3'b010): accum<=accum+1, wrapping mod 2**DATA_W.
- States:
  - IDLE: on accept go to EXEC (ALU ops), WR (000) or RD_ADDR (011).
  - EXEC: one cycle; updates the register; done=1; back to IDLE. Total latency is accept+1.
  - WR:
    - wr_ready=1. Each wr_valid&&wr_ready writes RAM[addr]<=wr_data, then addr<=addr+1 (wraps DEPTH-1 -> 0) and beat count+1.
    - When the BURST-th beat is accepted, blk_xfer is sampled in that same cycle.
    - If blk_xfer=1: the count clears and WR continues; addr keeps incrementing.
    - Else: done=1 next cycle, back to IDLE.
    - wr_valid low stalls without change.
  - RD_ADDR:
    - If the remaining count==0 (cmd_len=0): done, go to IDLE, no rd beat.
    - Else issue the RAM read at addr and go to RD_DATA.
  - RD_DATA:
    - rd_valid=1 and rd_data=RAM[addr], registered with 1-cycle read latency.
    - rd_data and rd_valid stay stable until rd_ready.
    - On handshake: addr+1 (wrap), remaining-1, then go to RD_ADDR. If remaining becomes 0: done, go to IDLE.
    - Throughput is 1 word per 2 cycles.
- cmd_len max is DEPTH. Reads wrap past DEPTH-1.
- done is a single-cycle pulse, asserted in the cycle the state returns to IDLE.
- accum is unaffected by WR/RD commands.

Decomposition:
- Package opcode_xfer_pkg:
  - state enum (IDLE, EXEC, WR, RD_ADDR, RD_DATA);
  - opcode constants (OP_ALU_OUT=3'b1??, OP_SWAP=3'b001, OP_INC=3'b010, OP_BLK_WR=3'b000, OP_LOAD=3'b011).
- One sub-module, xfer_ram:
  - single-port synchronous RAM, DATA_W x DEPTH, with we, addr, wdata, rdata;
  - 1-cycle read latency, no reset.
- The FSM, address/count logic and accum stay in the top level.

Test Plan:
- Reset, then OP_INC x3, then OP_SWAP -> accum goes 1,2,3, then 16'h0300. One done pulse per command, each 1 cycle after accept.
- OP_ALU_OUT (opcode 3'b110) after accum=16'h0300 -> alu_out=16'h0300 next cycle; accum unchanged.
- OP_BLK_WR addr=8'hFE with blk_xfer=0 and 5 beats 0xA0..0xA4 (wr_valid toggled every other cycle) -> RAM[FE,FF,00,01,02]=A0..A4 (wrap). done after the 5th beat.
- OP_BLK_WR with blk_xfer=1 for the first burst, 0 at the second -> 10 words written contiguously; exactly one done pulse.
- OP_LOAD addr=8'hFE len=5 with rd_ready low for 3 cycles on beat 2 -> rd_data sequence A0..A4; data held stable while stalled; done after the 5th handshake. With len=0 -> done, no rd_valid.
- Assert rst_n low mid-burst after 2 beats -> all outputs zero, cmd_ready=1 after release. RAM[FE],RAM[FF] retain the written data.
